// File: rtl/smi_port.sv
`default_nettype none
// ============================================================================
// smi_port : Raspberry Pi SMI slave - write FIFO, addressed reads, status word
// Rev 1.0
// ============================================================================
module smi_port #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 6,
    parameter int FIFO_DEPTH    = 16,
    parameter int CAPTURE_DELAY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    inout  wire  [DATA_WIDTH-1:0]            smi_data,
    input  logic [ADDR_WIDTH-1:0]            smi_sa,
    input  logic                             smi_oe,
    input  logic                             smi_we,
    output logic [DATA_WIDTH-1:0]            wr_data,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic                             wr_valid,
    input  logic                             wr_ready,
    output logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic                             rd_strobe,
    input  logic [DATA_WIDTH-1:0]            rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    output logic                             overflow
);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W  = $clog2(FIFO_DEPTH+1);
    localparam int c_STAT_W = DATA_WIDTH - 1;
    localparam int c_WORD_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_LVL_W-1:0] c_LVL_ONE = 1;
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(FIFO_DEPTH);

    logic                  r_oe_s1, r_oe_s2, r_oe_d;
    logic                  r_we_s1, r_we_s2, r_we_d;
    logic [ADDR_WIDTH-1:0] r_sa_s1, r_sa_s2;
    logic [DATA_WIDTH-1:0] r_dq_s1, r_dq_s2;
    logic                  w_wedet, w_oedet;

    // Strobes reset to their inactive (high) level so reset release creates no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_oe_s1 <= 1'b1;
            r_oe_s2 <= 1'b1;
            r_oe_d  <= 1'b1;
            r_we_s1 <= 1'b1;
            r_we_s2 <= 1'b1;
            r_we_d  <= 1'b1;
            r_sa_s1 <= '0;
            r_sa_s2 <= '0;
            r_dq_s1 <= '0;
            r_dq_s2 <= '0;
        end else begin
            r_oe_s1 <= smi_oe;
            r_oe_s2 <= r_oe_s1;
            r_oe_d  <= r_oe_s2;
            r_we_s1 <= smi_we;
            r_we_s2 <= r_we_s1;
            r_we_d  <= r_we_s2;
            r_sa_s1 <= smi_sa;
            r_sa_s2 <= r_sa_s1;
            r_dq_s1 <= smi_data;
            r_dq_s2 <= r_dq_s1;
        end
    end

    assign w_wedet = r_we_d & ~r_we_s2;
    assign w_oedet = r_oe_d & ~r_oe_s2 & ~w_wedet;

    logic                  w_push;
    logic [ADDR_WIDTH-1:0] w_push_addr;

    generate
        if (CAPTURE_DELAY == 0) begin : g_cap_direct
            assign w_push      = w_wedet;
            assign w_push_addr = r_sa_s2;
        end else begin : g_cap_delay
            logic [CAPTURE_DELAY-1:0] r_cap_vld;
            logic [ADDR_WIDTH-1:0]    r_cap_addr [CAPTURE_DELAY];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cap_vld <= '0;
                    for (int i = 0; i < CAPTURE_DELAY; i++) r_cap_addr[i] <= '0;
                end else begin
                    r_cap_vld[0] <= w_wedet;
                    if (w_wedet) r_cap_addr[0] <= r_sa_s2;
                    for (int i = 1; i < CAPTURE_DELAY; i++) begin
                        r_cap_vld[i]  <= r_cap_vld[i-1];
                        r_cap_addr[i] <= r_cap_addr[i-1];
                    end
                end
            end

            assign w_push      = r_cap_vld[CAPTURE_DELAY-1];
            assign w_push_addr = r_cap_addr[CAPTURE_DELAY-1];
        end
    endgenerate

    logic [c_WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr, r_rptr;
    logic [c_LVL_W-1:0]  r_level;
    logic                w_pop, w_full, w_accept, w_drop;

    assign wr_valid = (r_level != '0);
    assign w_pop    = wr_valid & wr_ready;
    assign w_full   = (r_level == c_LVL_FULL);
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;
    assign {wr_addr, wr_data} = r_mem[r_rptr];
    assign level    = r_level;

    // When full, a simultaneous push overwrites the slot being popped, which is safe.
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wptr] <= {w_push_addr, r_dq_s2};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)    r_rptr <= r_rptr + c_PTR_ONE;
            if (w_accept && !w_pop)      r_level <= r_level + c_LVL_ONE;
            else if (!w_accept && w_pop) r_level <= r_level - c_LVL_ONE;
        end
    end

    logic                  r_rd_pend, r_rd_stat, r_rd_strobe, r_oe_en, r_ovf;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0] r_rd_q;
    logic [DATA_WIDTH-1:0] w_status;
    logic                  w_drive;

    assign w_status  = {r_ovf, c_STAT_W'(r_level)};
    assign rd_addr   = r_rd_addr;
    assign rd_strobe = r_rd_strobe;
    assign overflow  = r_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pend   <= 1'b0;
            r_rd_stat   <= 1'b0;
            r_rd_strobe <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_q      <= '0;
            r_oe_en     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_rd_pend   <= w_oedet;
            r_rd_strobe <= 1'b0;
            if (w_oedet) begin
                r_rd_stat <= (r_sa_s2 == '0);
                if (r_sa_s2 != '0) begin
                    r_rd_addr   <= r_sa_s2;
                    r_rd_strobe <= 1'b1;
                end
            end
            if (r_rd_pend) r_rd_q <= r_rd_stat ? w_status : rd_data;
            if (r_oe_s2 || w_wedet) r_oe_en <= 1'b0;
            else if (r_rd_pend)     r_oe_en <= 1'b1;
            if (w_drop)                       r_ovf <= 1'b1;
            else if (r_rd_pend && r_rd_stat)  r_ovf <= 1'b0;
        end
    end

    // Release is combinational on synced OE high and never overlaps a Pi write.
    assign w_drive = r_oe_en & ~r_oe_s2 & r_we_s2;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_tristate
            assign smi_data[gi] = w_drive ? r_rd_q[gi] : 1'bz;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_smi_port.sv
`default_nettype none
// tb_smi_port : randomised self-checking bench for smi_port against a queue model.
module tb_smi_port;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH+1);
    localparam int SW    = DW - 1;
    localparam logic [DW-1:0] RELEASED = '1;

    logic          clk = 1'b0;
    logic          reset;
    wire  [DW-1:0] smi_data;
    logic [AW-1:0] smi_sa;
    logic          smi_oe, smi_we;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_strobe;
    logic [DW-1:0] rd_data;
    logic [LW-1:0] level;
    logic          overflow;

    logic          pi_drive;
    logic [DW-1:0] pi_data;

    int checks = 0;
    int errors = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] got_q[$];
    int               model_level = 0;
    bit               model_ovf   = 1'b0;
    int               strobe_cnt  = 0;

    smi_port #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CAPTURE_DELAY(1)
    ) dut (
        .clk(clk), .reset(reset), .smi_data(smi_data), .smi_sa(smi_sa),
        .smi_oe(smi_oe), .smi_we(smi_we), .wr_data(wr_data), .wr_addr(wr_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_addr(rd_addr),
        .rd_strobe(rd_strobe), .rd_data(rd_data), .level(level), .overflow(overflow)
    );

    assign smi_data = pi_drive ? pi_data : 'z;
    for (genvar gi = 0; gi < DW; gi++) begin : g_pull
        pullup (smi_data[gi]);
    end

    always #5 clk = ~clk;

    // Consumer-side monitor: a word is taken whenever valid and ready meet before an edge.
    always begin
        @(negedge clk);
        #2;
        if (wr_valid && wr_ready) got_q.push_back({wr_addr, wr_data});
        if (rd_strobe) strobe_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference model of one Pi write: accepted while not full or when a pop coincides.
    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit popping);
        if (model_level < DEPTH || popping) begin
            exp_q.push_back({a, d});
            if (!popping) model_level++;
        end else begin
            model_ovf = 1'b1;
        end
    endtask

    // mode 0: leave wr_ready, 1: one-cycle ready aligned with the push, 2: random ready
    task automatic pi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int mode);
        smi_sa = a; pi_data = d; pi_drive = 1'b1; smi_we = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (mode == 1) wr_ready = (k == 3);
            if (mode == 2) wr_ready = 1'($urandom_range(0, 1));
            if (k == 4) smi_we = 1'b1;
            if (k == 6) pi_drive = 1'b0;
        end
    endtask

    task automatic drain();
        wr_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        wr_ready = 1'b0;
        model_level = 0;
    endtask

    task automatic pi_read(input logic [AW-1:0] a, input logic [DW-1:0] rv,
                           input logic [DW-1:0] expv, input bit exp_strobe);
        int s0;
        s0 = strobe_cnt;
        rd_data = rv; smi_sa = a; smi_oe = 1'b0;
        repeat (3) tick();
        checks++;
        if (smi_data !== RELEASED) begin
            errors++; $display("FAIL rd_early_drive: bus %h, required released %h", smi_data, RELEASED);
        end
        tick();
        checks++;
        if (smi_data !== expv) begin
            errors++; $display("FAIL rd_drive_4cyc: bus %h, required %h", smi_data, expv);
        end
        repeat (2) tick();
        checks++;
        if (smi_data !== expv) begin
            errors++; $display("FAIL rd_drive_hold: bus %h, required %h", smi_data, expv);
        end
        smi_oe = 1'b1;
        tick();
        checks++;
        if (smi_data !== expv) begin
            errors++; $display("FAIL rd_drive_oe_unsynced: bus %h, required %h", smi_data, expv);
        end
        tick();
        checks++;
        if (smi_data !== RELEASED) begin
            errors++; $display("FAIL rd_release: bus %h, required %h", smi_data, RELEASED);
        end
        checks++;
        if ((strobe_cnt - s0) != (exp_strobe ? 1 : 0)) begin
            errors++; $display("FAIL rd_strobe_count: %0d pulses, required %0d", strobe_cnt - s0, exp_strobe ? 1 : 0);
        end
        if (exp_strobe) begin
            checks++;
            if (rd_addr !== a) begin
                errors++; $display("FAIL rd_addr: got %0d, required %0d", rd_addr, a);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; smi_oe = 1'b1; smi_we = 1'b1; smi_sa = '0;
        pi_drive = 1'b0; pi_data = '0; wr_ready = 1'b0; rd_data = '0;
        repeat (3) tick();
        checks++;
        if ({wr_valid, overflow, rd_strobe, level, rd_addr} !== '0) begin
            errors++; $display("FAIL reset_state: valid=%b ovf=%b strobe=%b level=%0d rd_addr=%0d, required all 0",
                               wr_valid, overflow, rd_strobe, level, rd_addr);
        end
        checks++;
        if (smi_data !== RELEASED) begin
            errors++; $display("FAIL reset_bus: bus %h, required %h", smi_data, RELEASED);
        end
        reset = 1'b0;
        repeat (4) tick();
        checks++;
        if (strobe_cnt != 0 || wr_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release_edge: strobes=%0d valid=%b, required 0 0", strobe_cnt, wr_valid);
        end
    endtask

    task automatic test_write_sequence();
        int base;
        logic [AW-1:0] aa [3];
        logic [DW-1:0] dd [3];
        base = exp_q.size();
        aa[0] = 6'd5; aa[1] = 6'd6; aa[2] = 6'd7;
        dd[0] = 8'hA1; dd[1] = 8'hB2; dd[2] = 8'hC3;
        wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pi_write(aa[i], dd[i], 0);
            model_write(aa[i], dd[i], 1'b1);
        end
        repeat (4) tick();
        wr_ready = 1'b0;
        model_level = 0;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL seq_count: got %0d words, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = base; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL seq_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (level !== LW'(model_level)) begin
            errors++; $display("FAIL seq_level: got %0d, required %0d", level, model_level);
        end
    endtask

    task automatic test_overflow_and_push_pop();
        int base;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] stat;
        base = exp_q.size();
        wr_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            a = AW'($urandom_range(1, (1 << AW) - 1));
            d = DW'($urandom);
            pi_write(a, d, 0);
            model_write(a, d, 1'b0);
        end
        checks++;
        if (level !== LW'(model_level) || overflow !== model_ovf) begin
            errors++; $display("FAIL ovf_state: level=%0d ovf=%b, required %0d %b", level, overflow, model_level, model_ovf);
        end
        checks++;
        if (wr_valid !== 1'b1 || {wr_addr, wr_data} !== exp_q[base]) begin
            errors++; $display("FAIL ovf_head_hold: valid=%b head=%h, required 1 %h", wr_valid, {wr_addr, wr_data}, exp_q[base]);
        end
        stat = {model_ovf, SW'(model_level)};
        pi_read('0, DW'($urandom), stat, 1'b0);
        model_ovf = 1'b0;
        checks++;
        if (overflow !== model_ovf) begin
            errors++; $display("FAIL ovf_clear: got %b, required %b", overflow, model_ovf);
        end
        a = AW'($urandom_range(1, (1 << AW) - 1));
        d = DW'($urandom);
        pi_write(a, d, 1);
        model_write(a, d, 1'b1);
        checks++;
        if (level !== LW'(model_level) || overflow !== model_ovf) begin
            errors++; $display("FAIL full_push_pop: level=%0d ovf=%b, required %0d %b", level, overflow, model_level, model_ovf);
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size() || level !== '0) begin
            errors++; $display("FAIL ovf_drain: got %0d words level %0d, required %0d words level 0",
                               got_q.size(), level, exp_q.size());
        end
        for (int i = base; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL ovf_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_addressed_read();
        logic [DW-1:0] v;
        pi_read(6'd3, 8'h5C, 8'h5C, 1'b1);
        for (int i = 0; i < 3; i++) begin
            v = DW'($urandom_range(0, 254));
            pi_read(AW'($urandom_range(1, (1 << AW) - 1)), v, v, 1'b1);
        end
    endtask

    task automatic test_random_stream();
        int base;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        base = exp_q.size();
        for (int i = 0; i < 10; i++) begin
            a = AW'($urandom);
            d = DW'($urandom);
            pi_write(a, d, 2);
            exp_q.push_back({a, d});
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size() || level !== '0) begin
            errors++; $display("FAIL rand_count: got %0d words level %0d, required %0d level 0",
                               got_q.size(), level, exp_q.size());
        end
        for (int i = base; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_collision_and_reset();
        int s0, g0;
        logic [AW-1:0] a;
        logic [DW-1:0] d, v;
        s0 = strobe_cnt;
        a = AW'($urandom_range(1, (1 << AW) - 1));
        d = DW'($urandom_range(0, 254));
        smi_sa = a; pi_data = d; pi_drive = 1'b1; smi_we = 1'b0; smi_oe = 1'b0;
        wr_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 4) smi_we = 1'b1;
            if (k == 6) pi_drive = 1'b0;
            if (k >= 7) begin
                checks++;
                if (smi_data !== RELEASED) begin
                    errors++; $display("FAIL collide_bus k%0d: bus %h, required %h", k, smi_data, RELEASED);
                end
            end
        end
        smi_oe = 1'b1;
        repeat (3) tick();
        wr_ready = 1'b0;
        exp_q.push_back({a, d});
        checks++;
        if (got_q.size() != exp_q.size() || got_q[got_q.size()-1] !== {a, d} || strobe_cnt != s0) begin
            errors++; $display("FAIL collide_write: words %0d last %h strobes %0d, required %0d %h 0",
                               got_q.size(), got_q[got_q.size()-1], strobe_cnt - s0, exp_q.size(), {a, d});
        end

        g0 = got_q.size();
        for (int i = 0; i < 4; i++) begin
            a = AW'($urandom); d = DW'($urandom);
            pi_write(a, d, 0);
            model_write(a, d, 1'b0);
        end
        checks++;
        if (level !== LW'(model_level)) begin
            errors++; $display("FAIL pre_reset_level: got %0d, required %0d", level, model_level);
        end
        v = DW'($urandom_range(0, 254));
        rd_data = v; smi_sa = 6'd3; smi_oe = 1'b0;
        repeat (4) tick();
        checks++;
        if (smi_data !== v) begin
            errors++; $display("FAIL pre_reset_drive: bus %h, required %h", smi_data, v);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (smi_data !== RELEASED || level !== '0 || wr_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: bus %h level %0d valid %b, required %h 0 0",
                               smi_data, level, wr_valid, RELEASED);
        end
        smi_oe = 1'b1;
        repeat (2) tick();
        s0 = strobe_cnt;
        reset = 1'b0;
        model_level = 0;
        model_ovf = 1'b0;
        while (exp_q.size() > g0) void'(exp_q.pop_back());
        repeat (6) tick();
        checks++;
        if (strobe_cnt != s0 || wr_valid !== 1'b0 || level !== '0 || overflow !== 1'b0 ||
            smi_data !== RELEASED || got_q.size() != g0) begin
            errors++; $display("FAIL post_reset: strobes %0d valid %b level %0d ovf %b bus %h popped %0d, required 0 0 0 0 %h 0",
                               strobe_cnt - s0, wr_valid, level, overflow, smi_data, got_q.size() - g0, RELEASED);
        end
    endtask

    initial begin
        test_reset();
        test_write_sequence();
        test_overflow_and_push_pop();
        test_addressed_read();
        test_random_stream();
        test_collision_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
